// File: rtl/dm_lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings (same as dm LOADSel),
// FSM states and access-size helpers.
package dm_lsu_pkg;

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LBU = 4'b0010;
    localparam logic [3:0] OP_LH  = 4'b0011;
    localparam logic [3:0] OP_LHU = 4'b0100;
    localparam logic [3:0] OP_SB  = 4'b0101;
    localparam logic [3:0] OP_SH  = 4'b0110;
    localparam logic [3:0] OP_SW  = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR,
        S_RESP
    } state_t;

    function automatic logic [2:0] size_of(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: size_of = 3'd1;
            OP_LH, OP_LHU, OP_SH: size_of = 3'd2;
            default:              size_of = 3'd4;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/dm_lsu_extract.sv
// Load data extraction: shifts the two-word window down by the byte offset,
// truncates to the access size and sign/zero-extends.
module dm_lsu_extract
    import dm_lsu_pkg::*;
(
    input  logic [63:0] words,
    input  logic [1:0]  o,
    input  logic [3:0]  op,
    output logic [31:0] data
);

    logic [31:0] win;

    function automatic logic [31:0] sext8(input logic signed [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    assign win = 32'(words >> {o, 3'b000});

    always_comb begin
        data = win;
        case (op)
            OP_LB:   data = sext8(win[7:0]);
            OP_LBU:  data = {24'b0, win[7:0]};
            OP_LH:   data = sext16(win[15:0]);
            OP_LHU:  data = {16'b0, win[15:0]};
            default: data = win;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit in front of dm: splits misaligned loads into two word reads
// and misaligned stores into per-byte sb beats, one response per request.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int DM_AW = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             dm_wr,
    output logic [3:0]       dm_loadsel,
    output logic [1:0]       dm_byte,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    input  logic [31:0]      dm_dout
);

    state_t           state, state_nx;
    logic [3:0]       op_q;
    logic [DM_AW-1:0] w_q;
    logic [1:0]       o_q;
    logic [31:0]      wdata_q;
    logic [31:0]      word0_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [1:0]       beat_q;

    logic             accept;
    logic [2:0]       size_q;
    logic             ld_mis;
    logic             st_mis;
    logic             last_beat;
    logic [2:0]       pos;
    logic [31:0]      word0_in;
    logic [31:0]      ext_data;
    logic             unused_addr;

    assign unused_addr = ^req_addr[31:DM_AW+2];

    assign req_ready = (state == S_IDLE) || (state == S_RESP);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign size_q    = size_of(op_q);
    assign ld_mis    = ({1'b0, o_q} + size_q) > 3'd4;
    // The dm sh mode only serves lanes 0 and 2, so an odd sh is split like a misaligned sw.
    assign st_mis    = ((op_q == OP_SH) && o_q[0]) || ((op_q == OP_SW) && (o_q != 2'd0));
    assign last_beat = !st_mis || ({1'b0, beat_q} == (size_q - 3'd1));
    assign pos       = {1'b0, o_q} + {1'b0, beat_q};

    assign word0_in = (state == S_RD1) ? word0_q : dm_dout;

    dm_lsu_extract u_extract (
        .words (({dm_dout, word0_in})),
        .o     (o_q),
        .op    (op_q),
        .data  (ext_data)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_RESP: begin
                state_nx = S_IDLE;
                if (accept) begin
                    if (req_op[3])
                        state_nx = S_RESP;
                    else if (is_store(req_op))
                        state_nx = S_WR;
                    else
                        state_nx = S_RD0;
                end
            end
            S_RD0:   state_nx = ld_mis ? S_RD1 : S_RESP;
            S_RD1:   state_nx = S_RESP;
            S_WR:    state_nx = last_beat ? S_RESP : S_WR;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        dm_loadsel = OP_LW;
        dm_byte    = 2'd0;
        dm_addr    = '0;
        dm_din     = 32'd0;
        case (state)
            S_RD0: dm_addr = w_q;
            S_RD1: dm_addr = w_q + DM_AW'(1);
            S_WR: begin
                if (st_mis) begin
                    dm_loadsel = OP_SB;
                    dm_byte    = pos[1:0];
                    dm_addr    = w_q + DM_AW'(pos[2]);
                    dm_din     = {24'b0, wdata_q[{beat_q, 3'b000} +: 8]};
                end else begin
                    dm_addr = w_q;
                    case (op_q)
                        OP_SB: begin
                            dm_loadsel = OP_SB;
                            dm_byte    = o_q;
                            dm_din     = {24'b0, wdata_q[7:0]};
                        end
                        OP_SH: begin
                            dm_loadsel = OP_SH;
                            dm_byte    = o_q;
                            dm_din     = o_q[1] ? {wdata_q[15:0], 16'b0} : {16'b0, wdata_q[15:0]};
                        end
                        default: begin
                            dm_loadsel = OP_SW;
                            dm_din     = wdata_q;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign dm_wr = (state == S_WR) && rstn;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            op_q    <= '0;
            w_q     <= '0;
            o_q     <= '0;
            wdata_q <= '0;
            word0_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        op_q    <= req_op;
                        w_q     <= req_addr[DM_AW+1:2];
                        o_q     <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        beat_q  <= '0;
                        rdata_q <= '0;
                        err_q   <= req_op[3];
                    end
                end
                S_RD0: begin
                    word0_q <= dm_dout;
                    if (!ld_mis)
                        rdata_q <= ext_data;
                end
                S_RD1:   rdata_q <= ext_data;
                S_WR:    beat_q  <= beat_q + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: behavioural dm word memory plus a byte-array reference
// model of the load/store semantics, directed and random scenarios.
module tb_dm_lsu;

    localparam logic [3:0] LW = 4'b0000, LB = 4'b0001, LBU = 4'b0010, LH = 4'b0011;
    localparam logic [3:0] LHU = 4'b0100, SB = 4'b0101, SH = 4'b0110, SW = 4'b0111;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dm_wr;
    logic [3:0]  dm_loadsel;
    logic [1:0]  dm_byte;
    logic [6:0]  dm_addr;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    int total = 0;
    int bad   = 0;

    // dm model: combinational read, lane writes on the rising edge
    logic [31:0] dmem [128];
    logic        pre_we = 1'b0;
    logic [6:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    // byte-level reference memory (512 bytes)
    logic [7:0]  rmem [512];

    logic [1:0]  lanes_q [$];
    logic [3:0]  ldsel_q [$];
    logic [31:0] din_q [$];
    logic [6:0]  rdaddr_q [$];
    bit          rd_sel_bad;

    dm_lsu #(.DM_AW(7)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dm_wr      (dm_wr),
        .dm_loadsel (dm_loadsel),
        .dm_byte    (dm_byte),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_dout    (dm_dout)
    );

    always #5 clk = ~clk;

    assign dm_dout = dmem[dm_addr];

    always @(posedge clk) begin
        if (dm_wr) begin
            case (dm_loadsel)
                SB: dmem[dm_addr][{dm_byte, 3'b000} +: 8] <= dm_din[7:0];
                SH: begin
                    if (dm_byte == 2'd0) dmem[dm_addr][15:0] <= dm_din[15:0];
                    else if (dm_byte == 2'd2) dmem[dm_addr][31:16] <= dm_din[31:16];
                end
                SW: dmem[dm_addr] <= dm_din;
                default: ;
            endcase
        end else if (pre_we) begin
            dmem[pre_idx] <= pre_val;
        end
    end

    function automatic int op_size(input logic [3:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return (op == SB || op == SH || op == SW);
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] v = 32'd0;
        int sz = op_size(op);
        for (int k = 0; k < sz; k++)
            v[8*k +: 8] = rmem[(int'(a[8:0]) + k) % 512];
        if (op == LB) v = {{24{v[7]}}, v[7:0]};
        if (op == LH) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic bit is_mis(input logic [3:0] op, input logic [31:0] a);
        int o = int'(a[1:0]);
        int sz = op_size(op);
        if (op_store(op)) return (o % sz) != 0;
        return (o + sz) > 4;
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] a);
        if (op[3]) return 1;
        if (op_store(op) && is_mis(op, a)) return 1 + op_size(op);
        if (!op_store(op) && is_mis(op, a)) return 3;
        return 2;
    endfunction

    function automatic int exp_nwr(input logic [3:0] op, input logic [31:0] a);
        if (op[3] || !op_store(op)) return 0;
        return is_mis(op, a) ? op_size(op) : 1;
    endfunction

    task automatic ref_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        for (int k = 0; k < op_size(op); k++)
            rmem[(int'(a[8:0]) + k) % 512] = wd[8*k +: 8];
    endtask

    task automatic preload_word(input int idx, input logic [31:0] val);
        pre_we  = 1'b1;
        pre_idx = 7'(idx);
        pre_val = val;
        for (int k = 0; k < 4; k++) rmem[4*idx + k] = val[8*k +: 8];
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issues one request from a negedge and collects what the DUT did until rsp_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nwr, output int waited);
        int  cyc = 0;
        bit  done = 0;
        lanes_q.delete(); ldsel_q.delete(); din_q.delete(); rdaddr_q.delete();
        rd_sel_bad = 0;
        waited = 0;
        nwr = 0;
        lat = -1;
        rd = 'x;
        er = 'x;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            if (rsp_valid) begin
                done = 1;
                lat  = cyc;
                rd   = rsp_rdata;
                er   = rsp_err;
            end else if (dm_wr) begin
                nwr++;
                lanes_q.push_back(dm_byte);
                ldsel_q.push_back(dm_loadsel);
                din_q.push_back(dm_din);
            end else begin
                rdaddr_q.push_back(dm_addr);
                if (dm_loadsel != LW) rd_sel_bad = 1;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 128; i++) preload_word(i, $urandom);
        preload_word(4, 32'h44332211);
        preload_word(5, 32'h88776655);
        preload_word(6, 32'h000000AA);
        preload_word(127, 32'h11223344);
        preload_word(0, 32'h55667788);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dm_wr !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl ready=%b rsp_valid=%b dm_wr=%b want 1 0 0", req_ready, rsp_valid, dm_wr);
        end
        total++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_data err=%b rdata=%h want 0 0", rsp_err, rsp_rdata);
        end
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dm_wr !== 1'b0) begin
            bad++;
            $display("FAIL post_reset ready=%b rsp_valid=%b dm_wr=%b", req_ready, rsp_valid, dm_wr);
        end
    endtask

    task automatic test_aligned_load();
        logic [31:0] rd; logic er; int lat, nwr, wt;
        run_op(LW, 32'h10, 32'h0, rd, er, lat, nwr, wt);
        total++;
        if (rd !== 32'h44332211 || lat != 2 || er !== 1'b0) begin
            bad++;
            $display("FAIL lw_aligned rdata=%h lat=%0d err=%b want 44332211 2 0", rd, lat, er);
        end
        total++;
        if (rdaddr_q.size() != 1 || rdaddr_q[0] !== 7'd4 || rd_sel_bad) begin
            bad++;
            $display("FAIL lw_aligned_reads n=%0d selbad=%0d want one read of word 4", rdaddr_q.size(), rd_sel_bad);
        end
    endtask

    task automatic test_misaligned_load();
        logic [31:0] rd; logic er; int lat, nwr, wt;
        run_op(LW, 32'h13, 32'h0, rd, er, lat, nwr, wt);
        total++;
        if (rd !== ref_load(LW, 32'h13) || lat != 3) begin
            bad++;
            $display("FAIL lw_mis rdata=%h lat=%0d want %h 3", rd, lat, ref_load(LW, 32'h13));
        end
        total++;
        if (rdaddr_q.size() != 2 || rdaddr_q[0] !== 7'd4 || rdaddr_q[1] !== 7'd5 || rd_sel_bad) begin
            bad++;
            $display("FAIL lw_mis_reads n=%0d selbad=%0d want words 4,5", rdaddr_q.size(), rd_sel_bad);
        end
    endtask

    task automatic test_extend();
        logic [3:0]  ops [3] = '{LH, LHU, LB};
        logic [31:0] want [3] = '{32'hFFFFAA88, 32'h0000AA88, 32'hFFFFFF88};
        logic [31:0] rd; logic er; int lat, nwr, wt;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'h17, 32'h0, rd, er, lat, nwr, wt);
            total++;
            if (rd !== want[i] || lat != exp_lat(ops[i], 32'h17)) begin
                bad++;
                $display("FAIL extend op=%h rdata=%h lat=%0d want %h %0d", ops[i], rd, lat, want[i], exp_lat(ops[i], 32'h17));
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] rd; logic er; int lat, nwr, wt;
        bit lanes_ok = 1;
        run_op(SW, 32'h11, 32'hDEADBEEF, rd, er, lat, nwr, wt);
        ref_store(SW, 32'h11, 32'hDEADBEEF);
        for (int k = 0; k < lanes_q.size(); k++)
            if (lanes_q[k] !== 2'((1 + k) % 4) || ldsel_q[k] !== SB) lanes_ok = 0;
        total++;
        if (lat != 5 || nwr != 4 || !lanes_ok || rd !== 32'd0) begin
            bad++;
            $display("FAIL sw_mis lat=%0d beats=%0d lanes_ok=%0d rdata=%h want 5 4 1 0", lat, nwr, lanes_ok, rd);
        end
        run_op(LW, 32'h10, 32'h0, rd, er, lat, nwr, wt);
        total++;
        if (rd !== 32'hADBEEF11) begin
            bad++;
            $display("FAIL sw_mis_word4 got=%h want ADBEEF11", rd);
        end
        run_op(LW, 32'h14, 32'h0, rd, er, lat, nwr, wt);
        total++;
        if (rd !== 32'h887766DE) begin
            bad++;
            $display("FAIL sw_mis_word5 got=%h want 887766DE", rd);
        end
        run_op(SH, 32'h12, 32'h0000CAFE, rd, er, lat, nwr, wt);
        ref_store(SH, 32'h12, 32'h0000CAFE);
        total++;
        if (lat != 2 || nwr != 1 || ldsel_q.size() != 1 || ldsel_q[0] !== SH || din_q[0][31:16] !== 16'hCAFE) begin
            bad++;
            $display("FAIL sh_lane2 lat=%0d beats=%0d want 2 1 with loadsel 0110 din[31:16]=CAFE", lat, nwr);
        end
        run_op(LW, 32'h10, 32'h0, rd, er, lat, nwr, wt);
        total++;
        if (rd !== 32'hCAFEEF11 || rd !== ref_load(LW, 32'h10)) begin
            bad++;
            $display("FAIL sh_readback got=%h want CAFEEF11", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat, nwr, wt;
        run_op(LW, 32'h1FD, 32'h0, rd, er, lat, nwr, wt);
        total++;
        if (rd !== 32'h88112233 || lat != 3) begin
            bad++;
            $display("FAIL wrap rdata=%h lat=%0d want 88112233 3", rd, lat);
        end
        total++;
        if (rdaddr_q.size() != 2 || rdaddr_q[0] !== 7'd127 || rdaddr_q[1] !== 7'd0) begin
            bad++;
            $display("FAIL wrap_reads n=%0d want words 127,0", rdaddr_q.size());
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat, nwr, wt;
        run_op(4'b1010, 32'h10, 32'hFFFFFFFF, rd, er, lat, nwr, wt);
        total++;
        if (er !== 1'b1 || lat != 1 || nwr != 0 || rd !== 32'd0) begin
            bad++;
            $display("FAIL illegal err=%b lat=%0d beats=%0d rdata=%h want 1 1 0 0", er, lat, nwr, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, nwr, wt;
        run_op(LW, 32'h14, 32'h0, rd, er, lat, nwr, wt);
        run_op(SB, 32'h1A, 32'h0000005A, rd, er, lat, nwr, wt);
        ref_store(SB, 32'h1A, 32'h0000005A);
        total++;
        if (wt != 0 || lat != 2 || nwr != 1 || er !== 1'b0) begin
            bad++;
            $display("FAIL b2b waited=%0d lat=%0d beats=%0d err=%b want 0 2 1 0", wt, lat, nwr, er);
        end
        run_op(LBU, 32'h1A, 32'h0, rd, er, lat, nwr, wt);
        total++;
        if (wt != 0 || rd !== 32'h0000005A) begin
            bad++;
            $display("FAIL b2b_readback waited=%0d got=%h want 0 0000005A", wt, rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd; logic er; int lat, nwr, wt;
        logic [3:0] op;
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            a  = $urandom;
            wd = $urandom;
            run_op(op, a, wd, rd, er, lat, nwr, wt);
            total++;
            if (lat != exp_lat(op, a) || nwr != exp_nwr(op, a) || er !== op[3]) begin
                bad++;
                $display("FAIL rand_ctl op=%h addr=%h lat=%0d beats=%0d err=%b want %0d %0d %b",
                         op, a[8:0], lat, nwr, er, exp_lat(op, a), exp_nwr(op, a), op[3]);
            end
            if (op[3] || op_store(op)) begin
                if (!op[3]) ref_store(op, a, wd);
                total++;
                if (rd !== 32'd0) begin
                    bad++;
                    $display("FAIL rand_rdata_zero op=%h got=%h want 0", op, rd);
                end
            end else begin
                total++;
                if (rd !== ref_load(op, a)) begin
                    bad++;
                    $display("FAIL rand_load op=%h addr=%h got=%h want %h", op, a[8:0], rd, ref_load(op, a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat, nwr, wt;
        logic [31:0] wd = 32'hA1B2C3D4;
        bit seen = 0;
        req_valid = 1'b1; req_op = SW; req_addr = 32'h21; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (dm_wr !== 1'b1 || dm_byte !== 2'd1 || dm_addr !== 7'd8) begin
            bad++;
            $display("FAIL rstmid_beat0 wr=%b lane=%0d word=%0d want 1 1 8", dm_wr, dm_byte, dm_addr);
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if (dm_wr !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_wr_gate dm_wr=%b want 0", dm_wr);
        end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        rmem[9'h21] = wd[7:0];
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dm_wr !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_idle ready=%b rsp_valid=%b dm_wr=%b want 1 0 0", req_ready, rsp_valid, dm_wr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || dm_wr) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rstmid_quiet got activity after reset want none");
        end
        run_op(LW, 32'h20, 32'h0, rd, er, lat, nwr, wt);
        total++;
        if (rd !== ref_load(LW, 32'h20)) begin
            bad++;
            $display("FAIL rstmid_word8 got=%h want %h", rd, ref_load(LW, 32'h20));
        end
    endtask

    task automatic test_mem_image();
        logic [31:0] want;
        int nbad = 0;
        for (int i = 0; i < 128; i++) begin
            want = {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
            if (dmem[i] !== want) begin
                nbad++;
                if (nbad < 5) $display("FAIL mem_image word=%0d got=%h want %h", i, dmem[i], want);
            end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL mem_image_total words_wrong=%0d want 0", nbad);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_misaligned_load();
        test_extend();
        test_store();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_mem_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
